cb_arbiter: RTL
===============

// Module: cb_arbiter
// PURPOSE
//  Output-side scheduler for the 4x4 crossbar `cb`. Watches the flit presented by each input
//  port (co0..co3), arbitrates header requests per output port with round-robin, and drives the
//  one-hot grant vectors ack0..ack3 that steer `cb`.
//  Holds each grant for one whole packet (header..tail) so packets never interleave on an output.
// PARAMETERS
//  NPORT  4   number of input ports and output ports (ack width = NPORT)
//  PKTW   10  flit width: [PKTW-1:PKTW-2] type, [PKTW-3:0] payload
//  DSTW   2   destination field width; header payload bits [DSTW-1:0] = output index
// PORTS
//  clk     in   1      single clock, rising edge
//  rst_n   in   1      asynchronous, active-low reset
//  co0..3  in   PKTW   flit currently offered by input port i (same nets that feed cb)
//  ack0..3 out  NPORT  grant for output j: bit i=1 -> input i owns output j; one-hot or zero
//  busy    out  NPORT  busy[j]=1 while output j holds a grant (equals |ackj)
// BEHAVIOUR
//  Flit types: 2'b00 idle, 2'b10 header, 2'b01 body, 2'b11 tail.
//  Reset: all ackj=0, busy=0, every rr pointer=NPORT-1 (input 0 has top priority first).
//   Assertion mid-packet clears all grants immediately; no packet state survives reset.
//  Per output j, 2-state FSM, all outputs are registered:
//   IDLE: req_j[i] = (coi type==header) && (coi[DSTW-1:0]==j) && (input i not granted elsewhere).
//    Any req_j -> pick first set bit after ptr_j (wrapping modulo NPORT); ackj<=onehot(i),
//    ptr_j<=i, go BUSY. Grant visible one cycle after the header is first sampled.
//   BUSY: owner = granted input. Body and idle flits from the owner keep the grant.
//    Tail on owner at an edge -> ackj<=0, go IDLE; earliest regrant is the following edge, so the
//    output has at least one grant-free cycle between packets.
//    A header from the owner while BUSY is a protocol error: ignore it and keep the grant.
//  Header from a non-owner while BUSY: not granted; it keeps waiting (the input stalls on ack=0).
//  Different outputs arbitrate independently and may grant in the same cycle.
//  One input targets exactly one output per packet, so no input is ever granted to two outputs
//   (the req_j mask enforces this). Invariant: each input bit is set in at most one ackj.
//  Fairness: an input waiting with a header is granted within NPORT-1 packets on its output.
//  Unused payload bits above DSTW are ignored for routing.
// STRUCTURE
//  Shared package sw_pkg (extends sw.vh): NPORT, PKTW, DSTW, the flit-type localparams
//   (FT_IDLE/FT_HEAD/FT_BODY/FT_TAIL), typedef flit_t, function dst_of(flit_t).
//  Sub-module rr_arb (one per output, generate loop): req[NPORT], grant one-hot, ptr register,
//   state register. cb_arbiter decodes the requests and ORs the grants for the mask.
// TESTING
//  1 reset: rst_n=0 with traffic present -> ack0..3=0, busy=0; release -> no grant until a header.
//  2 single packet: co0=10_00000011 at edge N -> ack3=0001 from N+1; 01_x body flits hold it;
//    11_00000000 at edge M -> ack3=0000 from M+1, busy[3]=0.
//  3 contention: co0,co1,co2 all header dest 1 together -> grants in order 0001,0010,0100
//    over three packets; input 0 then re-requests -> wins after 2 (round robin).
//  4 parallel: co0 hdr dest 2, co3 hdr dest 0 at same edge -> ack2=0001 and ack0=1000 next cycle.
//  5 errors: owner sends header mid-packet -> grant unchanged; idle bubbles mid-packet -> unchanged.
//  6 reset mid-packet: drop rst_n while ack3=0001 -> ack3=0 asynchronously; the first header
//    after release arbitrates with ptr=NPORT-1 (input 0 first).

Source files
------------

// File: rtl/cb_arbiter_pkg.sv
// Shared crossbar definitions: sizes, flit encoding, and decode/arbitration helpers.
package cb_arbiter_pkg;

    localparam int NPORT = 4;
    localparam int PKTW  = 10;
    localparam int DSTW  = 2;
    localparam int PTRW  = $clog2(NPORT);

    localparam logic [1:0] FT_IDLE = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_BODY = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef logic [PKTW-1:0]  flit_t;
    typedef logic [NPORT-1:0] vec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    function automatic logic [1:0] ftype_of(flit_t f);
        return f[PKTW-1:PKTW-2];
    endfunction

    // Only the low DSTW payload bits route; the rest of the payload is ignored.
    function automatic logic [DSTW-1:0] dst_of(flit_t f);
        return f[DSTW-1:0];
    endfunction

    // Round-robin search: first set request strictly after ptr, wrapping.
    // Returns {found, index}.
    function automatic logic [PTRW:0] rr_pick(vec_t req, logic [PTRW-1:0] ptr);
        int              c;
        logic            found;
        logic [PTRW-1:0] idx;
        found = 1'b0;
        idx   = ptr;
        for (int k = 1; k <= NPORT; k++) begin
            c = (int'(ptr) + k) % NPORT;
            if (!found && req[c[PTRW-1:0]]) begin
                found = 1'b1;
                idx   = c[PTRW-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/cb_arbiter_if.sv
// Flit observation and grant bus between the crossbar inputs and the arbiter.
interface cb_arbiter_if;
    import cb_arbiter_pkg::*;

    flit_t co0;
    flit_t co1;
    flit_t co2;
    flit_t co3;
    vec_t  ack0;
    vec_t  ack1;
    vec_t  ack2;
    vec_t  ack3;
    vec_t  busy;

    modport master (
        output co0, co1, co2, co3,
        input  ack0, ack1, ack2, ack3, busy
    );

    modport slave (
        input  co0, co1, co2, co3,
        output ack0, ack1, ack2, ack3, busy
    );

endinterface

// File: rtl/cb_arbiter_rr_arb.sv
// Per-output round-robin arbiter that holds its grant from header to tail.
module cb_arbiter_rr_arb
    import cb_arbiter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  vec_t req_i,
    input  vec_t tail_i,
    output vec_t grant_o,
    output logic busy_o
);

    arb_state_e      state_q, state_d;
    vec_t            grant_q, grant_d;
    logic [PTRW-1:0] ptr_q,   ptr_d;
    logic [PTRW:0]   pick;

    // State, grant and priority pointer; reset restores input 0 as first choice.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= PTRW'(NPORT - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Grant a waiting header when idle; release only on a tail from the owner.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        pick    = rr_pick(req_i, ptr_q);
        case (state_q)
            ST_IDLE: begin
                if (pick[PTRW]) begin
                    grant_d = vec_t'(1) << pick[PTRW-1:0];
                    ptr_d   = pick[PTRW-1:0];
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (|(grant_q & tail_i)) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign grant_o = grant_q;
    assign busy_o  = |grant_q;

endmodule

// File: rtl/cb_arbiter.sv
// Output-side scheduler for the 4x4 crossbar: decodes header requests per
// output, masks inputs already owning an output, and runs one arbiter per output.
module cb_arbiter
    import cb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    cb_arbiter_if.slave bus
);

    flit_t flit  [NPORT];
    vec_t  req   [NPORT];
    vec_t  grant [NPORT];
    vec_t  tail;
    vec_t  granted_any;
    vec_t  busy;

    assign flit[0] = bus.co0;
    assign flit[1] = bus.co1;
    assign flit[2] = bus.co2;
    assign flit[3] = bus.co3;

    // Inputs that currently own some output; they may not request another.
    always_comb begin
        granted_any = '0;
        for (int j = 0; j < NPORT; j++) begin
            granted_any = granted_any | grant[j];
        end
    end

    // Header requests per output and tail detection per input.
    always_comb begin
        tail = '0;
        for (int j = 0; j < NPORT; j++) begin
            req[j] = '0;
        end
        for (int i = 0; i < NPORT; i++) begin
            tail[i] = (ftype_of(flit[i]) == FT_TAIL);
            for (int j = 0; j < NPORT; j++) begin
                req[j][i] = (ftype_of(flit[i]) == FT_HEAD) &&
                            (dst_of(flit[i]) == DSTW'(j)) &&
                            !granted_any[i];
            end
        end
    end

    for (genvar j = 0; j < NPORT; j++) begin : g_out
        cb_arbiter_rr_arb u_arb (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .req_i   (req[j]),
            .tail_i  (tail),
            .grant_o (grant[j]),
            .busy_o  (busy[j])
        );
    end

    assign bus.ack0 = grant[0];
    assign bus.ack1 = grant[1];
    assign bus.ack2 = grant[2];
    assign bus.ack3 = grant[3];
    assign bus.busy = busy;

endmodule
